// File: rtl/delay_sequencer_if.sv
// delay_sequencer_if: control and timer handshake bundle between a sequencer and its user
interface delay_sequencer_if #(parameter int STEP_W = 2);
  logic start;
  logic abort;
  logic timer_done;
  logic timer_enable;
  logic [STEP_W-1:0] step;
  logic step_valid;
  logic busy;
  logic finished;
  logic error;
  modport master (
    output start, abort, timer_done,
    input  timer_enable, step, step_valid, busy, finished, error
  );
  modport slave (
    input  start, abort, timer_done,
    output timer_enable, step, step_valid, busy, finished, error
  );
endinterface

// File: rtl/delay_sequencer.sv
// delay_sequencer: walks a delay timer through NUM_STEPS enable/done/release handshakes with a watchdog
module delay_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic clk,
  input logic rst_n,
  delay_sequencer_if.slave bus
);
  localparam int STEP_W = $clog2(NUM_STEPS) > 1 ? $clog2(NUM_STEPS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, REL = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] wd;
  logic [STEP_W-1:0] step;
  logic timer_enable, step_valid, busy, finished, error;
  logic last, expire;
  assign last = step == STEP_W'(NUM_STEPS - 1);
  assign expire = (TIMEOUT_CYCLES != 0) && (wd == CW'(TIMEOUT_CYCLES - 1));
  // a done edge or release completion always wins over the watchdog on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wd <= '0;
      step <= '0;
      timer_enable <= 1'b0;
      step_valid <= 1'b0;
      busy <= 1'b0;
      finished <= 1'b0;
      error <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      finished <= 1'b0;
      wd <= wd + 1'b1;
      if (state == IDLE) begin
        wd <= '0;
        if (bus.start) begin
          state <= ARM;
          step <= '0;
          error <= 1'b0;
          timer_enable <= 1'b1;
          busy <= 1'b1;
        end
      end else if (bus.abort) begin
        state <= IDLE;
        wd <= '0;
        timer_enable <= 1'b0;
        busy <= 1'b0;
      end else if (state == ARM && bus.timer_done) begin
        state <= REL;
        wd <= '0;
        timer_enable <= 1'b0;
        step_valid <= 1'b1;
      end else if (state == REL && !bus.timer_done) begin
        wd <= '0;
        if (last) begin
          state <= IDLE;
          busy <= 1'b0;
          finished <= 1'b1;
        end else begin
          state <= ARM;
          step <= step + 1'b1;
          timer_enable <= 1'b1;
        end
      end else if (expire || state == 2'd3) begin
        state <= IDLE;
        wd <= '0;
        timer_enable <= 1'b0;
        busy <= 1'b0;
        error <= expire;
      end
    end
  end
  assign bus.timer_enable = timer_enable;
  assign bus.step = step;
  assign bus.step_valid = step_valid;
  assign bus.busy = busy;
  assign bus.finished = finished;
  assign bus.error = error;
endmodule

// File: tb/tb_delay_sequencer.sv
// tb_delay_sequencer: directed checks of delay_sequencer against a 5-cycle delay timer model
module tb_delay_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tdone = 1'b0;
  int checks = 0;
  int errors = 0;
  int mode = 0;
  int cnt = 0;
  always #5 clk = ~clk;
  delay_sequencer_if #(.STEP_W(2)) bus();
  assign bus.timer_done = tdone;
  delay_sequencer #(.NUM_STEPS(3), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  // timer model: mode 0 normal, 1 done never rises, 2 done sticks high once risen
  always @(posedge clk) begin
    if (mode == 2 && tdone) tdone <= 1'b1;
    else if (bus.timer_enable !== 1'b1) begin
      cnt <= 0;
      tdone <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      tdone <= (mode != 1) && (cnt >= 4);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_outs(string tag, logic en, logic b, logic sv, logic fin, logic er);
    chk({tag, ".timer_enable"}, bus.timer_enable, en);
    chk({tag, ".busy"}, bus.busy, b);
    chk({tag, ".step_valid"}, bus.step_valid, sv);
    chk({tag, ".finished"}, bus.finished, fin);
    chk({tag, ".error"}, bus.error, er);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    tick();
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.step", bus.step, 0);
    #2 rst_n = 1'b1;
    tick();
    chk_outs("idle", 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      bus.start = 1'b0;
      chk_outs("nominal", e <= 24 && ((e - 1) % 8) < 6, e <= 24, e == 7 || e == 15 || e == 23, e == 25, 0);
      if (e == 7 || e == 15 || e == 23) chk("nominal.step", bus.step, (e - 1) / 8);
    end
    mode = 1;
    bus.start = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      tick();
      bus.start = 1'b0;
      chk_outs("stuck_low", e <= 20, e <= 20, 0, 0, e == 21);
    end
    tick();
    tick();
    chk_outs("stuck_low.sticky", 0, 0, 0, 0, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_outs("stuck_low.restart", 1, 1, 0, 0, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_outs("stuck_low.abort", 0, 0, 0, 0, 0);
    mode = 2;
    tick();
    bus.start = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      tick();
      bus.start = 1'b0;
      chk_outs("stuck_high", e <= 6, e <= 26, e == 7, 0, e == 27);
      if (e == 7) chk("stuck_high.step", bus.step, 0);
    end
    mode = 0;
    tick();
    tick();
    bus.start = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      bus.start = 1'b0;
    end
    chk_outs("abort.armed", 1, 1, 0, 0, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_outs("abort", 0, 0, 0, 0, 0);
    chk("abort.step", bus.step, 0);
    for (int e = 8; e <= 10; e++) begin
      tick();
      chk_outs("abort.after", 0, 0, 0, 0, 0);
    end
    bus.start = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      chk_outs("start_held", (e <= 24 && ((e - 1) % 8) < 6) || e == 26, e <= 24 || e == 26,
               e == 7 || e == 15 || e == 23, e == 25, 0);
      if (e == 7 || e == 15 || e == 23 || e == 26) chk("start_held.step", bus.step, e == 26 ? 0 : (e - 1) / 8);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_outs("start_held.abort", 0, 0, 0, 0, 0);
    tick();
    tick();
    bus.start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      bus.start = 1'b0;
    end
    chk_outs("async.armed", 1, 1, 0, 0, 0);
    chk("async.armed.step", bus.step, 1);
    #3 rst_n = 1'b0;
    #1;
    chk_outs("async.reset", 0, 0, 0, 0, 0);
    chk("async.reset.step", bus.step, 0);
    tick();
    #2 rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk_outs("async.idle", 0, 0, 0, 0, 0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_outs("async.restart", 1, 1, 0, 0, 0);
    chk("async.restart.step", bus.step, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
